// File: rtl/rtc_sched_pkg.sv
// Shared definitions for the RTC bus scheduler, its sequencers and the bus mux:
// state encoding, bus_sel codes and default transaction lengths.
package rtc_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_WRITE,
        ST_READ,
        ST_GAP
    } sched_state_t;

    localparam logic [1:0] SEL_NONE  = 2'b00;
    localparam logic [1:0] SEL_INIT  = 2'b01;
    localparam logic [1:0] SEL_WRITE = 2'b10;
    localparam logic [1:0] SEL_READ  = 2'b11;

    localparam int DEF_READ_CYCLES  = 352;
    localparam int DEF_WRITE_CYCLES = 352;
    localparam int DEF_INIT_CYCLES  = 72;
    localparam int DEF_GAP_CYCLES   = 8;
    localparam int DEF_READ_PERIOD  = 1_000_000;

    function automatic int max_of4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // Bits needed to count 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rtc_period_timer.sv
// Free-running 0..READ_PERIOD-1 counter; tick is high while the count sits on
// its last value, so it lasts exactly one cycle per period.
module rtc_period_timer
    import rtc_sched_pkg::*;
#(
    parameter int READ_PERIOD = DEF_READ_PERIOD
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = cnt_width(READ_PERIOD);
    localparam logic [CW-1:0] LAST = CW'(READ_PERIOD - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/rtc_bus_scheduler.sv
// Owns the RTC parallel bus: grants init, write or periodic read sequencers one
// at a time, holds their do_it level for a fixed length, then a guard gap.
module rtc_bus_scheduler
    import rtc_sched_pkg::*;
#(
    parameter int READ_CYCLES  = DEF_READ_CYCLES,
    parameter int WRITE_CYCLES = DEF_WRITE_CYCLES,
    parameter int INIT_CYCLES  = DEF_INIT_CYCLES,
    parameter int GAP_CYCLES   = DEF_GAP_CYCLES,
    parameter int READ_PERIOD  = DEF_READ_PERIOD
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en_lectura,
    input  logic       req_write,
    output logic       do_it_init,
    output logic       do_it_escribir,
    output logic       do_it_leer,
    output logic [1:0] bus_sel,
    output logic       busy,
    output logic       init_done,
    output logic       write_ack,
    output logic       read_done,
    output logic       read_overrun
);

    localparam int CNT_W = cnt_width(max_of4(READ_CYCLES, WRITE_CYCLES, INIT_CYCLES, GAP_CYCLES));
    localparam logic [CNT_W-1:0] READ_LAST  = CNT_W'(READ_CYCLES - 1);
    localparam logic [CNT_W-1:0] WRITE_LAST = CNT_W'(WRITE_CYCLES - 1);
    localparam logic [CNT_W-1:0] INIT_LAST  = CNT_W'(INIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

    sched_state_t     state;
    logic [CNT_W-1:0] dur_cnt;
    logic             phase_last;
    logic             init_pend;
    logic             wr_pend;
    logic             rd_pend;
    logic             tick;
    logic             read_tick;
    logic             grant_init;
    logic             grant_write;
    logic             grant_read;

    rtc_period_timer #(
        .READ_PERIOD(READ_PERIOD)
    ) u_period_timer (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    assign read_tick = tick & en_lectura;

    // Grants only happen from IDLE; writes and reads wait for a completed init.
    assign grant_init  = (state == ST_IDLE) & init_pend;
    assign grant_write = (state == ST_IDLE) & ~init_pend & init_done & wr_pend;
    assign grant_read  = (state == ST_IDLE) & ~init_pend & init_done & ~wr_pend & rd_pend;

    // A new request arriving on the grant edge survives the clear and is served later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            init_pend    <= 1'b1;
            wr_pend      <= 1'b0;
            rd_pend      <= 1'b0;
            read_overrun <= 1'b0;
        end else begin
            if (grant_init) begin
                init_pend <= 1'b0;
            end
            wr_pend      <= req_write | (wr_pend & ~grant_write);
            rd_pend      <= read_tick | (rd_pend & ~grant_read);
            read_overrun <= read_tick & rd_pend;
        end
    end

    always_comb begin
        phase_last = 1'b0;
        case (state)
            ST_INIT:  phase_last = (dur_cnt == INIT_LAST);
            ST_WRITE: phase_last = (dur_cnt == WRITE_LAST);
            ST_READ:  phase_last = (dur_cnt == READ_LAST);
            ST_GAP:   phase_last = (dur_cnt == GAP_LAST);
            default:  phase_last = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            dur_cnt        <= '0;
            do_it_init     <= 1'b0;
            do_it_escribir <= 1'b0;
            do_it_leer     <= 1'b0;
            bus_sel        <= SEL_NONE;
            init_done      <= 1'b0;
            write_ack      <= 1'b0;
            read_done      <= 1'b0;
        end else begin
            write_ack <= 1'b0;
            read_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    dur_cnt <= '0;
                    if (grant_init) begin
                        state      <= ST_INIT;
                        do_it_init <= 1'b1;
                        bus_sel    <= SEL_INIT;
                    end else if (grant_write) begin
                        state          <= ST_WRITE;
                        do_it_escribir <= 1'b1;
                        bus_sel        <= SEL_WRITE;
                    end else if (grant_read) begin
                        state      <= ST_READ;
                        do_it_leer <= 1'b1;
                        bus_sel    <= SEL_READ;
                    end
                end
                ST_INIT, ST_WRITE, ST_READ: begin
                    if (phase_last) begin
                        state          <= ST_GAP;
                        dur_cnt        <= '0;
                        do_it_init     <= 1'b0;
                        do_it_escribir <= 1'b0;
                        do_it_leer     <= 1'b0;
                        bus_sel        <= SEL_NONE;
                        init_done      <= init_done | (state == ST_INIT);
                        write_ack      <= (state == ST_WRITE);
                        read_done      <= (state == ST_READ);
                    end else begin
                        dur_cnt <= dur_cnt + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (phase_last) begin
                        state   <= ST_IDLE;
                        dur_cnt <= '0;
                    end else begin
                        dur_cnt <= dur_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state          <= ST_IDLE;
                    dur_cnt        <= '0;
                    do_it_init     <= 1'b0;
                    do_it_escribir <= 1'b0;
                    do_it_leer     <= 1'b0;
                    bus_sel        <= SEL_NONE;
                end
            endcase
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_rtc_bus_scheduler.sv
// Scoreboard bench for rtc_bus_scheduler: a timestamp-based reference model
// predicts every transaction start, completion pulse and overrun per cycle.
module tb_rtc_bus_scheduler;
    import rtc_sched_pkg::*;

    localparam int P  = 1000;
    localparam int RC = DEF_READ_CYCLES;
    localparam int WC = DEF_WRITE_CYCLES;
    localparam int IC = DEF_INIT_CYCLES;
    localparam int GC = DEF_GAP_CYCLES;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en_lectura = 1'b0;
    logic       req_write = 1'b0;
    logic       do_it_init;
    logic       do_it_escribir;
    logic       do_it_leer;
    logic [1:0] bus_sel;
    logic       busy;
    logic       init_done;
    logic       write_ack;
    logic       read_done;
    logic       read_overrun;

    rtc_bus_scheduler #(
        .READ_CYCLES (RC),
        .WRITE_CYCLES(WC),
        .INIT_CYCLES (IC),
        .GAP_CYCLES  (GC),
        .READ_PERIOD (P)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .en_lectura    (en_lectura),
        .req_write     (req_write),
        .do_it_init    (do_it_init),
        .do_it_escribir(do_it_escribir),
        .do_it_leer    (do_it_leer),
        .bus_sel       (bus_sel),
        .busy          (busy),
        .init_done     (init_done),
        .write_ack     (write_ack),
        .read_done     (read_done),
        .read_overrun  (read_overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int kind;
    } ev_t;

    typedef struct {
        int         cyc;
        logic [1:0] sel;
        logic       busy;
        logic       done;
    } lv_t;

    ev_t evq[$];
    lv_t lvq[$];

    int errors = 0;
    int checks = 0;
    int timeouts = 0;
    bit fin_req = 1'b0;

    // Model state: cycle index since reset release, pending requests and the
    // current transaction as (kind, start cycle, length); idle_at is the first
    // cycle after the gap.
    int cyc = 0;
    bit m_init, m_wr, m_rd, m_done;
    int cur_kind, cur_start, cur_len, idle_at;

    function automatic int len_of(input int k);
        case (k)
            1:       return IC;
            2:       return WC;
            default: return RC;
        endcase
    endfunction

    function automatic string ev_name(input int k);
        case (k)
            1:       return "start_init";
            2:       return "start_write";
            3:       return "start_read";
            4:       return "init_done";
            5:       return "write_ack";
            6:       return "read_done";
            7:       return "read_overrun";
            default: return "unknown";
        endcase
    endfunction

    initial begin : model
        int g;
        bit tick, ovr;
        forever begin
            @(posedge clk);
            if (reset) begin
                cyc = 0; m_init = 1'b1; m_wr = 1'b0; m_rd = 1'b0; m_done = 1'b0;
                cur_kind = 0; cur_start = 0; cur_len = 0; idle_at = 0;
                evq.delete();
                lvq.delete();
            end else begin
                cyc++;
                tick = (((cyc - 1) % P) == P - 1);
                g = 0;
                if (cyc - 1 >= idle_at) begin
                    if (m_init)               g = 1;
                    else if (m_done && m_wr)  g = 2;
                    else if (m_done && m_rd)  g = 3;
                end
                ovr    = tick && en_lectura && m_rd;
                m_init = m_init && (g != 1);
                m_wr   = req_write || (m_wr && (g != 2));
                m_rd   = (tick && en_lectura) || (m_rd && (g != 3));
                if (g != 0) begin
                    cur_kind = g; cur_start = cyc; cur_len = len_of(g);
                    idle_at = cyc + cur_len + GC;
                    evq.push_back('{cyc: cyc, kind: g});
                end
                if (cur_kind != 0 && cyc == cur_start + cur_len) begin
                    if (cur_kind == 1) m_done = 1'b1;
                    evq.push_back('{cyc: cyc, kind: cur_kind + 3});
                end
                if (ovr) evq.push_back('{cyc: cyc, kind: 7});
                lvq.push_back('{cyc: cyc,
                                sel: (cur_kind != 0 && cyc < cur_start + cur_len) ? 2'(cur_kind) : 2'b00,
                                busy: (cyc < idle_at),
                                done: m_done});
            end
        end
    end

    task automatic checkOutput(input string name, input int c, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: got 0x%0h, required 0x%0h", name, c, act, req);
        end
    endtask

    task automatic matchEvent(input int c, input int k);
        ev_t ev;
        checks++;
        if (evq.size() == 0) begin
            errors++;
            $display("[TB] FAIL event_%s cycle %0d: DUT presented it, scoreboard expected nothing", ev_name(k), c);
        end else begin
            ev = evq.pop_front();
            if (ev.kind != k || ev.cyc != c) begin
                errors++;
                $display("[TB] FAIL event_%s: got %s at cycle %0d, required %s at cycle %0d",
                         ev_name(k), ev_name(k), c, ev_name(ev.kind), ev.cyc);
            end
        end
    endtask

    initial begin : monitor
        lv_t        lv;
        ev_t        ev;
        logic [2:0] prev_do;
        logic       prev_done;
        logic [6:0] exp_v;
        int         last_cyc;
        prev_do = '0; prev_done = 1'b0; last_cyc = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_do = '0; prev_done = 1'b0;
                checkOutput("reset_state", last_cyc,
                            32'({do_it_leer, do_it_escribir, do_it_init, bus_sel, busy,
                                 init_done, write_ack, read_done, read_overrun}), 32'd0);
            end else if (lvq.size() > 0) begin
                lv = lvq.pop_front();
                last_cyc = lv.cyc;
                while (evq.size() > 0 && evq[0].cyc < lv.cyc) begin
                    ev = evq.pop_front();
                    checks++;
                    errors++;
                    $display("[TB] FAIL missed_%s: got nothing by cycle %0d, required at cycle %0d",
                             ev_name(ev.kind), lv.cyc, ev.cyc);
                end
                exp_v = {lv.sel == SEL_READ, lv.sel == SEL_WRITE, lv.sel == SEL_INIT,
                         lv.sel, lv.busy, lv.done};
                checkOutput("levels(leer,escr,init,sel,busy,done)", lv.cyc,
                            32'({do_it_leer, do_it_escribir, do_it_init, bus_sel, busy, init_done}),
                            32'(exp_v));
                if (do_it_init && !prev_do[0])     matchEvent(lv.cyc, 1);
                if (do_it_escribir && !prev_do[1]) matchEvent(lv.cyc, 2);
                if (do_it_leer && !prev_do[2])     matchEvent(lv.cyc, 3);
                if (init_done && !prev_done)       matchEvent(lv.cyc, 4);
                if (write_ack)                     matchEvent(lv.cyc, 5);
                if (read_done)                     matchEvent(lv.cyc, 6);
                if (read_overrun)                  matchEvent(lv.cyc, 7);
                prev_do   = {do_it_leer, do_it_escribir, do_it_init};
                prev_done = init_done;
            end
            if (fin_req) begin
                checkOutput("scoreboard_drained", last_cyc, 32'(evq.size()), 32'd0);
                checkOutput("wait_timeouts", last_cyc, 32'(timeouts), 32'd0);
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end
        end
    end

    // req_mode: 0 = low, 1 = held high, 2 = sparse random with random en_lectura.
    task automatic applyStimulus(input int n, input int req_mode, input logic en_v);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (req_mode == 2) begin
                if (i % 400 == 0) en_lectura = ($urandom_range(0, 3) != 0);
                req_write = ($urandom_range(0, 149) == 0);
            end else begin
                en_lectura = en_v;
                req_write  = (req_mode == 1);
            end
        end
    endtask

    initial begin : stimulus
        bit found;
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        $display("[TB] init run with a write request during INIT");
        applyStimulus(19, 0, 1'b0);
        applyStimulus(1, 1, 1'b0);
        applyStimulus(900, 0, 1'b0);
        $display("[TB] periodic reads");
        applyStimulus(2200, 0, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 2 * P; i++) begin
            @(posedge clk);
            #1;
            if (cyc % P == P - 2) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) timeouts++;
        $display("[TB] write request coinciding with a read tick");
        applyStimulus(1, 1, 1'b1);
        applyStimulus(1000, 0, 1'b1);
        $display("[TB] writes starving reads across several ticks");
        applyStimulus(2500, 1, 1'b1);
        applyStimulus(800, 0, 1'b1);
        $display("[TB] random traffic");
        applyStimulus(8000, 2, 1'b1);
        $display("[TB] reset in the middle of a read sweep");
        applyStimulus(1, 0, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            if (do_it_leer) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) timeouts++;
        repeat (99) @(posedge clk);
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        applyStimulus(29, 0, 1'b1);
        applyStimulus(1, 1, 1'b1);
        applyStimulus(1500, 0, 1'b1);
        fin_req = 1'b1;
    end

endmodule
